// File: rtl/safe_zone_gen.sv
// Raster-order generator of a pseudo-random safe/unsafe cell map with a forced-safe
// spawn square, plus NUM_PORTS registered pixel-coordinate lookup ports.
module safe_zone_gen #(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BLOCK_SIZE    = 10,
  parameter int NUM_PORTS     = 2,
  parameter int RAND_WIDTH    = 8,
  parameter logic [RAND_WIDTH:0] THR0 = 64,
  parameter logic [RAND_WIDTH:0] THR1 = 128,
  parameter logic [RAND_WIDTH:0] THR2 = 192,
  parameter logic [RAND_WIDTH:0] THR3 = 64,
  parameter int SPAWN_X    = 0,
  parameter int SPAWN_Y    = 0,
  parameter int SPAWN_SIZE = 3,
  localparam int XW = $clog2(SCREEN_WIDTH),
  localparam int YW = $clog2(SCREEN_HEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_regenerate_level,
  input  logic [15:0]               i_seed,
  output logic                      o_rdy,
  output logic                      o_done,
  input  logic [NUM_PORTS*XW-1:0]   i_x,
  input  logic [NUM_PORTS*YW-1:0]   i_y,
  output logic [NUM_PORTS-1:0]      o_is_safe
);
  localparam int GRID_W = SCREEN_WIDTH / BLOCK_SIZE;
  localparam int GRID_H = SCREEN_HEIGHT / BLOCK_SIZE;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int AW     = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int CXW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int CYW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  typedef enum logic {IDLE, GEN} state_t;

  state_t                state_q;
  logic [CXW-1:0]        cx_q;
  logic [CYW-1:0]        cy_q;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [GRID_W-1:0]     line_q;
  logic                  left_q, ul_q;
  logic                  map_valid_q, rdy_q, done_q;
  logic [NUM_PORTS-1:0]  safe_q;
  logic                  map_q [CELLS];

  logic                  upper, upleft, left, in_spawn, cell_d, last_cell;
  logic [1:0]            nbr;
  logic [RAND_WIDTH:0]   thr;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr [NUM_PORTS];
  logic                  rd_ok   [NUM_PORTS];

  // Upper-left is the line-buffer value read one cell earlier, captured before overwrite.
  always_comb begin
    upper    = (cy_q != '0) ? line_q[cx_q] : 1'b0;
    upleft   = (cy_q != '0 && cx_q != '0) ? ul_q : 1'b0;
    left     = (cx_q != '0) ? left_q : 1'b0;
    nbr      = {1'b0, upper} + {1'b0, left} + {1'b0, upleft};
    case (nbr)
      2'd0:    thr = THR0;
      2'd1:    thr = THR1;
      2'd2:    thr = THR2;
      default: thr = THR3;
    endcase
    in_spawn = (32'(cx_q) >= SPAWN_X) && (32'(cx_q) < SPAWN_X + SPAWN_SIZE) &&
               (32'(cy_q) >= SPAWN_Y) && (32'(cy_q) < SPAWN_Y + SPAWN_SIZE);
    cell_d   = in_spawn || ({1'b0, lfsr_q[RAND_WIDTH-1:0]} < thr);
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    last_cell = (cx_q == CXW'(GRID_W - 1)) && (cy_q == CYW'(GRID_H - 1));
    wr_addr  = AW'(32'(cy_q) * GRID_W + 32'(cx_q));
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_ok[p]   = map_valid_q && (state_q == IDLE) &&
                   (32'(i_x[p*XW +: XW]) < SCREEN_WIDTH) &&
                   (32'(i_y[p*YW +: YW]) < SCREEN_HEIGHT);
      rd_addr[p] = AW'((32'(i_y[p*YW +: YW]) / BLOCK_SIZE) * GRID_W +
                       32'(i_x[p*XW +: XW]) / BLOCK_SIZE);
    end
  end

  // A regenerate pulse is honoured in any state; reset overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      lfsr_q      <= 16'hACE1;
      line_q      <= '0;
      left_q      <= 1'b0;
      ul_q        <= 1'b0;
      map_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      safe_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_regenerate_level) begin
        state_q     <= GEN;
        cx_q        <= '0;
        cy_q        <= '0;
        lfsr_q      <= (i_seed == 16'h0000) ? 16'hACE1 : i_seed;
        map_valid_q <= 1'b0;
        rdy_q       <= 1'b0;
      end else if (state_q == GEN) begin
        lfsr_q       <= lfsr_d;
        line_q[cx_q] <= cell_d;
        left_q       <= cell_d;
        ul_q         <= line_q[cx_q];
        if (last_cell) begin
          state_q     <= IDLE;
          cx_q        <= '0;
          cy_q        <= '0;
          done_q      <= 1'b1;
          map_valid_q <= 1'b1;
          rdy_q       <= 1'b1;
        end else if (cx_q == CXW'(GRID_W - 1)) begin
          cx_q <= '0;
          cy_q <= cy_q + 1'b1;
        end else begin
          cx_q <= cx_q + 1'b1;
        end
      end
      for (int p = 0; p < NUM_PORTS; p++)
        safe_q[p] <= rd_ok[p] && map_q[rd_addr[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == GEN)
      map_q[wr_addr] <= cell_d;
  end

  assign o_rdy     = rdy_q;
  assign o_done    = done_q;
  assign o_is_safe = safe_q;
endmodule
